// File: rtl/johnson_phase_decoder.sv
// Samples an N-bit Johnson code and registers the decoded phase (binary + one-hot).
// Tracks lock to the legal 2N-step sequence and counts errors and full revolutions.
module johnson_phase_decoder #(
  parameter int N     = 4,
  parameter int CNT_W = 8,
  localparam int PH = 2 * N,
  localparam int PW = $clog2(PH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             code_valid,
  input  logic [0:N-1]     code_in,
  input  logic             clr_err,
  output logic [PW-1:0]    phase,
  output logic [PH-1:0]    phase_onehot,
  output logic             phase_valid,
  output logic             locked,
  output logic             wrap_pulse,
  output logic             invalid_code,
  output logic             seq_error,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] rev_count
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  // Legal code for phase k: ones fill from the left for k<=N, then zeros fill from the left.
  function automatic logic [0:N-1] jpat(input int k);
    logic [0:N-1] p;
    for (int i = 0; i < N; i++)
      p[i] = (k <= N) ? (i < k) : (i >= k - N);
    return p;
  endfunction

  state_t           state_q, state_d;
  logic             legal;
  logic [PW-1:0]    dec_idx, succ;
  logic [PW-1:0]    phase_d;
  logic [PH-1:0]    onehot_d;
  logic             pv_d, wrap_d, inv_d, seq_d, err_ev;
  logic             sticky_d;
  logic [CNT_W-1:0] err_cnt_d, rev_cnt_d;

  always_comb begin
    legal   = 1'b0;
    dec_idx = '0;
    for (int k = 0; k < PH; k++) begin
      if (code_in == jpat(k)) begin
        legal   = 1'b1;
        dec_idx = PW'(k);
      end
    end
  end

  assign succ = (phase == PW'(PH - 1)) ? '0 : phase + 1'b1;

  always_comb begin
    state_d = state_q;
    phase_d = phase;
    pv_d    = phase_valid;
    wrap_d  = 1'b0;
    inv_d   = 1'b0;
    seq_d   = 1'b0;
    if (code_valid) begin
      if (!legal) begin
        inv_d   = 1'b1;
        pv_d    = 1'b0;
        state_d = UNLOCKED;
      end else begin
        phase_d = dec_idx;
        pv_d    = 1'b1;
        state_d = LOCKED;
        // Sequence is only checked once locked; the first legal sample just acquires.
        if (state_q == LOCKED) begin
          if (dec_idx == succ) wrap_d = (phase == PW'(PH - 1));
          else                 seq_d  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    onehot_d = '0;
    for (int k = 0; k < PH; k++)
      onehot_d[k] = pv_d && (phase_d == PW'(k));
  end

  assign err_ev = inv_d | seq_d;

  // A same-cycle error beats clr_err: the count restarts at one rather than zero.
  always_comb begin
    sticky_d  = err_sticky;
    err_cnt_d = err_count;
    if (err_ev) begin
      sticky_d  = 1'b1;
      err_cnt_d = clr_err ? CNT_W'(1) :
                  (&err_count) ? err_count : err_count + 1'b1;
    end else if (clr_err) begin
      sticky_d  = 1'b0;
      err_cnt_d = '0;
    end
    rev_cnt_d = rev_count + CNT_W'(wrap_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UNLOCKED;
      phase        <= '0;
      phase_onehot <= '0;
      phase_valid  <= 1'b0;
      wrap_pulse   <= 1'b0;
      invalid_code <= 1'b0;
      seq_error    <= 1'b0;
      err_sticky   <= 1'b0;
      err_count    <= '0;
      rev_count    <= '0;
    end else begin
      state_q      <= state_d;
      phase        <= phase_d;
      phase_onehot <= onehot_d;
      phase_valid  <= pv_d;
      wrap_pulse   <= wrap_d;
      invalid_code <= inv_d;
      seq_error    <= seq_d;
      err_sticky   <= sticky_d;
      err_count    <= err_cnt_d;
      rev_count    <= rev_cnt_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed-vector bench for johnson_phase_decoder at N=4, CNT_W=8.
module tb_johnson_phase_decoder;
  localparam int N = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             code_valid;
  logic [0:N-1]     code_in;
  logic             clr_err;
  logic [2:0]       phase;
  logic [7:0]       phase_onehot;
  logic             phase_valid, locked, wrap_pulse, invalid_code, seq_error, err_sticky;
  logic [CNT_W-1:0] err_count, rev_count;

  int cmp = 0;
  int mis = 0;
  logic [0:N-1] jc [0:7];

  johnson_phase_decoder #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code_in(code_in), .clr_err(clr_err),
    .phase(phase), .phase_onehot(phase_onehot), .phase_valid(phase_valid), .locked(locked),
    .wrap_pulse(wrap_pulse), .invalid_code(invalid_code), .seq_error(seq_error),
    .err_sticky(err_sticky), .err_count(err_count), .rev_count(rev_count)
  );

  always #5 clk = ~clk;

  // Drive one cycle, then observe 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [0:N-1] c, input logic clr);
    code_valid = v; code_in = c; clr_err = clr;
    @(posedge clk); #1;
    code_valid = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; code_valid = 1'b0; code_in = '0; clr_err = 1'b0;
    repeat (2) @(posedge clk); #1;
    cmp++;
    if ({phase, phase_onehot, phase_valid, locked, wrap_pulse, invalid_code, seq_error,
         err_sticky, err_count, rev_count} !== '0) begin
      mis++; $display("FAIL reset: outputs not all zero (phase=%0d oh=%b lk=%b ec=%0d)",
                      phase, phase_onehot, locked, err_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sequence;
    for (int k = 0; k <= 8; k++) begin
      step(1'b1, jc[k % 8], 1'b0);
      cmp++;
      if (locked !== 1'b1 || phase !== 3'(k % 8) || phase_valid !== 1'b1 ||
          phase_onehot !== (8'd1 << (k % 8)) || seq_error !== 1'b0 || invalid_code !== 1'b0) begin
        mis++; $display("FAIL seq_phase%0d: phase=%0d oh=%b lk=%b pv=%b se=%b ic=%b", k,
                        phase, phase_onehot, locked, phase_valid, seq_error, invalid_code);
      end
      cmp++;
      if (wrap_pulse !== (k == 8)) begin
        mis++; $display("FAIL seq_wrap%0d: wrap=%b want %b", k, wrap_pulse, k == 8);
      end
    end
    cmp++;
    if (rev_count !== 8'd1 || err_count !== 8'd0 || err_sticky !== 1'b0) begin
      mis++; $display("FAIL seq_counts: rev=%0d err=%0d sticky=%b want 1/0/0",
                      rev_count, err_count, err_sticky);
    end
  endtask

  task automatic test_seq_error;
    step(1'b1, 4'b1000, 1'b0);
    step(1'b1, 4'b1100, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    cmp++;
    if (seq_error !== 1'b1 || phase !== 3'd4 || err_count !== 8'd1 || err_sticky !== 1'b1 ||
        locked !== 1'b1 || wrap_pulse !== 1'b0) begin
      mis++; $display("FAIL seq_error: se=%b phase=%0d ec=%0d st=%b lk=%b want 1/4/1/1/1",
                      seq_error, phase, err_count, err_sticky, locked);
    end
    step(1'b1, 4'b0111, 1'b0);
    cmp++;
    if (seq_error !== 1'b0 || phase !== 3'd5) begin
      mis++; $display("FAIL seq_resync: se=%b phase=%0d want 0/5", seq_error, phase);
    end
  endtask

  task automatic test_invalid;
    step(1'b1, 4'b1010, 1'b0);
    cmp++;
    if (invalid_code !== 1'b1 || phase_valid !== 1'b0 || locked !== 1'b0 ||
        phase_onehot !== 8'd0 || err_count !== 8'd2) begin
      mis++; $display("FAIL invalid: ic=%b pv=%b lk=%b oh=%b ec=%0d want 1/0/0/0/2",
                      invalid_code, phase_valid, locked, phase_onehot, err_count);
    end
    step(1'b1, 4'b0011, 1'b0);
    cmp++;
    if (locked !== 1'b1 || phase !== 3'd6 || seq_error !== 1'b0 || invalid_code !== 1'b0 ||
        err_count !== 8'd2 || phase_onehot !== 8'b0100_0000) begin
      mis++; $display("FAIL relock: lk=%b phase=%0d se=%b ec=%0d want 1/6/0/2",
                      locked, phase, seq_error, err_count);
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, (i % 2) ? 4'b1010 : 4'b1111, 1'b0);
      cmp++;
      if (phase !== 3'd6 || locked !== 1'b1 || phase_valid !== 1'b1 ||
          {wrap_pulse, invalid_code, seq_error} !== 3'b000 || err_count !== 8'd2) begin
        mis++; $display("FAIL hold%0d: phase=%0d lk=%b pulses=%b ec=%0d", i, phase, locked,
                        {wrap_pulse, invalid_code, seq_error}, err_count);
      end
    end
    step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    cmp++;
    if (phase !== 3'd0 || wrap_pulse !== 1'b1 || rev_count !== 8'd2 || seq_error !== 1'b0 ||
        err_count !== 8'd2) begin
      mis++; $display("FAIL resume: phase=%0d wrap=%b rev=%0d se=%b ec=%0d want 0/1/2/0/2",
                      phase, wrap_pulse, rev_count, seq_error, err_count);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 300; i++) step(1'b1, 4'b0101, 1'b0);
    cmp++;
    if (err_count !== 8'd255 || locked !== 1'b0 || invalid_code !== 1'b1) begin
      mis++; $display("FAIL saturate: ec=%0d lk=%b ic=%b want 255/0/1", err_count, locked, invalid_code);
    end
    step(1'b1, 4'b1001, 1'b1);
    cmp++;
    if (err_count !== 8'd1 || err_sticky !== 1'b1) begin
      mis++; $display("FAIL clr_vs_err: ec=%0d st=%b want 1/1", err_count, err_sticky);
    end
    step(1'b1, 4'b0000, 1'b1);
    cmp++;
    if (err_count !== 8'd0 || err_sticky !== 1'b0 || locked !== 1'b1 || phase !== 3'd0 ||
        rev_count !== 8'd2) begin
      mis++; $display("FAIL clr_err: ec=%0d st=%b lk=%b phase=%0d rev=%0d want 0/0/1/0/2",
                      err_count, err_sticky, locked, phase, rev_count);
    end
  endtask

  task automatic test_async_reset;
    for (int k = 1; k <= 5; k++) step(1'b1, jc[k], 1'b0);
    cmp++;
    if (phase !== 3'd5 || locked !== 1'b1) begin
      mis++; $display("FAIL pre_reset: phase=%0d lk=%b want 5/1", phase, locked);
    end
    #2 rst_n = 1'b0;
    #1;
    cmp++;
    if ({phase, phase_onehot, phase_valid, locked, rev_count} !== '0) begin
      mis++; $display("FAIL async_reset: phase=%0d oh=%b pv=%b lk=%b rev=%0d want all 0",
                      phase, phase_onehot, phase_valid, locked, rev_count);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 4'b0111, 1'b0);
    cmp++;
    if (locked !== 1'b1 || phase !== 3'd5 || seq_error !== 1'b0 || err_count !== 8'd0) begin
      mis++; $display("FAIL post_reset: lk=%b phase=%0d se=%b ec=%0d want 1/5/0/0",
                      locked, phase, seq_error, err_count);
    end
  endtask

  initial begin
    jc[0] = 4'b0000; jc[1] = 4'b1000; jc[2] = 4'b1100; jc[3] = 4'b1110;
    jc[4] = 4'b1111; jc[5] = 4'b0111; jc[6] = 4'b0011; jc[7] = 4'b0001;
    test_reset;
    test_sequence;
    test_seq_error;
    test_invalid;
    test_hold;
    test_saturation;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule

// File: doc/johnson_phase_decoder.md
Name: johnson_phase_decoder

Overview:
- Downstream consumer of the Johnson counter: samples its N-bit code and registers the decoded phase as a binary index and a one-hot vector.
- Tracks lock to the legal 2N-state sequence and flags invalid codes (the 2^N-2N unused states) and out-of-sequence steps.
- Counts errors and full revolutions.
- Used by phase-sequenced control logic and by the self-check of the counter stage.

Parameters:
- N, 4, Johnson code width; 2N legal phases; N >= 2.
- CNT_W, 8, width of err_count and rev_count.
- PW (localparam), $clog2(2N), width of the phase index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- code_valid  in  1  code_in is sampled this cycle.
- code_in  in  [0:N-1]  Johnson code; bit 0 is the leftmost bit, which receives the inverted bit N-1 on each step.
- clr_err  in  1  synchronous clear of err_sticky and err_count.
- phase  out  PW  decoded phase index, 0..2N-1.
- phase_onehot  out  2N  bit k is high when phase==k.
- phase_valid  out  1  phase and phase_onehot hold a legal sampled code.
- locked  out  1  FSM is in LOCKED.
- wrap_pulse  out  1  one-cycle pulse on the step from phase 2N-1 to phase 0 while locked.
- invalid_code  out  1  one-cycle pulse: sampled code is not one of the 2N legal codes.
- seq_error  out  1  one-cycle pulse: legal code that is not the successor of the previous phase while locked.
- err_sticky  out  1  set by any error; held until clr_err.
- err_count  out  CNT_W  saturating error count.
- rev_count  out  CNT_W  wrapping count of wrap_pulse events.

Behaviour:
- Reset (rst_n=0, async): all outputs 0, FSM in UNLOCKED, phase_onehot all zero.
- Decode map (index 0 first):
  - Phase k for 0<=k<=N: bits 0..k-1 are 1, the rest are 0.
  - Phase k for N<k<2N: bits 0..k-N-1 are 0, the rest are 1.
  - N=4 sequence: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7.
  - Any other code is invalid.
- Latency: all outputs are registered 1 cycle after the sampling edge (code_valid=1).
- code_valid=0: phase, phase_onehot, phase_valid, locked, counters hold; all pulses are 0.
- FSM transitions, on a sample:
  - UNLOCKED, legal code: load phase, phase_valid=1, go LOCKED; no sequence check.
  - UNLOCKED, invalid code: invalid_code=1, error recorded, phase_valid=0, phase_onehot=0, stay UNLOCKED.
  - LOCKED, legal code == (phase+1) mod 2N: load phase, stay LOCKED.
  - LOCKED, same condition with previous phase 2N-1: also wrap_pulse=1, rev_count+1 (wraps modulo 2^CNT_W).
  - LOCKED, legal code that is not the successor (including a repeat of the same phase): seq_error=1, error recorded, load the new phase (resync), stay LOCKED, no wrap_pulse.
  - LOCKED, invalid code: invalid_code=1, error recorded, phase_valid=0, phase_onehot=0, go UNLOCKED.
- Error recorded means: err_sticky=1 and err_count+1, saturating at 2^CNT_W-1.
- clr_err=1: err_sticky=0, err_count=0.
  - If an error is recorded in the same cycle, the error wins: err_sticky=1, err_count=1.
- clr_err does not affect the FSM, phase, or rev_count.
- Reset asserted mid-sequence: outputs clear immediately; after release, the first legal sample relocks with no seq_error.

Test Plan:
- Reset, then feed 0000,1000,...,0001,0000 with code_valid=1 each cycle (N=4) -> locked=1 after the first sample; phase 0..7,0 one cycle late; wrap_pulse once; rev_count=1; no errors.
- While locked at phase 2 (1100), feed 1111 -> seq_error pulse; phase=4; err_count=1; err_sticky=1; locked stays 1.
- While locked, feed 1010 -> invalid_code pulse; phase_valid=0; locked=0. Then feed 0011 -> locked=1, phase=6, no seq_error; err_count=2.
- Hold code_valid=0 for 5 cycles mid-sequence with code_in changing -> outputs frozen, no pulses. Resume with the successor -> no error.
- Inject 300 invalid codes with CNT_W=8 -> err_count saturates at 255. Assert clr_err in the same cycle as a further error -> err_count=1, err_sticky=1.
- Assert rst_n=0 asynchronously between clock edges while locked at phase 5 -> all outputs 0 immediately. Release, feed 0111 -> locked, phase=5, no seq_error.
